dense_4_argmax: RTL
===================

DENSE_4_ARGMAX -- requirements
Module: dense_4_argmax

Interface
REQ-001 SHALL have parameter WIDTH, default 19: bit width of each signed input score.
REQ-002 SHALL have parameter NFRAC, default 9: fractional bits of the scores; passed through, no effect on comparisons.
REQ-003 SHALL have parameter N_CLASSES, default 5: number of scores per vector; legal range 2..16.
REQ-004 SHALL have parameter IDX_W, default 3: index width, equal to ceil(log2(N_CLASSES)).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_data, input, N_CLASSES*WIDTH bits: signed two's-complement scores from the dense_4 stage; class k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-010 SHALL have port out_class, output, IDX_W bits: index of the maximum score.
REQ-011 SHALL have port out_max, output, WIDTH bits signed: the maximum score.
REQ-012 SHALL have port out_margin, output, WIDTH+1 bits unsigned: maximum score minus second-highest score.
REQ-013 SHALL have port out_valid, input/output direction output, 1 bit: result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-016 SHALL drive in_ready high only in IDLE and out_valid high only in DONE, both as registered or state-decoded signals with no combinational path from in_valid or out_ready.
REQ-017 SHALL, in IDLE with in_valid=1, capture in_data, set best=score[0], best_idx=0, second=-2^(WIDTH-1), ptr=1, and go to SCAN.
REQ-018 SHALL, in SCAN, compare one element per cycle, score[ptr], then increment ptr.
REQ-019 SHALL, when score[ptr] > best (signed, strict), set second=best, best=score[ptr], best_idx=ptr.
REQ-020 SHALL, when score[ptr] <= best and score[ptr] > second, set second=score[ptr].
REQ-021 SHALL resolve ties to the lowest index; an equal score never replaces best, but an equal score does update second.
REQ-022 SHALL, on the cycle in which ptr == N_CLASSES-1 is processed, register out_class, out_max, and out_margin = best - second, computed at WIDTH+1 bits with no overflow, and go to DONE.
REQ-023 SHALL have a latency of N_CLASSES-1 edges from the accepting edge to the edge at which out_valid rises (4 edges at default parameters).
REQ-024 SHALL hold out_class, out_max, and out_margin stable while out_valid=1 and out_ready=0, with no timeout.
REQ-025 SHALL, in DONE with out_ready=1, return to IDLE, with in_ready high in the following cycle.
REQ-026 SHALL sustain a peak throughput of one vector per N_CLASSES+1 cycles.
REQ-027 SHALL ignore in_data and in_valid outside IDLE; changes to in_data during SCAN do not affect the result.

Reset
REQ-028 SHALL, on reset asserted at any time including mid-SCAN or in DONE, immediately force state=IDLE, out_valid=0, out_class=0, out_max=0, out_margin=0, ptr=0, and internal best/second=0, and discard the vector in flight.
REQ-029 SHALL drive in_ready to 0 while reset is high and to 1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL pass: raw scores {-32,-33,-36,42,110}, out_ready=1 -> out_class=4, out_max=110, out_margin=68, out_valid rising 4 edges after acceptance and lasting 1 cycle.
REQ-031 SHALL pass: all scores 0 -> out_class=0, out_max=0, out_margin=0.
REQ-032 SHALL pass: {-262144,-262144,-262144,-262144,262143} -> out_class=4, out_max=262143, out_margin=524287 (no wrap).
REQ-033 SHALL pass: result with out_ready held 0 for 10 cycles while in_valid=1 with new data -> outputs stable, in_ready=0, new vector accepted only after out_ready handshake.
REQ-034 SHALL pass: reset pulsed on the second SCAN cycle -> out_valid never rises for that vector, in_ready=1 after reset, next vector {5,7,7,1,0} -> out_class=1, out_margin=0.
REQ-035 SHALL pass: back-to-back vectors with in_valid and out_ready held high -> accepts spaced exactly 6 cycles apart and all results correct.

Source files
------------

// File: rtl/dense_4_argmax.sv
// Sequential argmax over one vector of signed scores: one comparison per cycle.
// Reports the winning class, its score, and its margin over the runner-up.
module dense_4_argmax #(
    parameter int WIDTH     = 19,
    parameter int NFRAC     = 9,
    parameter int N_CLASSES = 5,
    parameter int IDX_W     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLASSES*WIDTH-1:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [IDX_W-1:0]              out_class,
    output logic signed [WIDTH-1:0]       out_max,
    output logic [WIDTH:0]                out_margin,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(N_CLASSES - 1);
    localparam logic signed [WIDTH-1:0] MIN_SCORE = {1'b1, {(WIDTH-1){1'b0}}};

    // Reject parameter sets the index/score widths cannot represent.
    generate
        if (N_CLASSES < 2 || N_CLASSES > 16 || NFRAC < 0 || NFRAC >= WIDTH ||
            (1 << IDX_W) < N_CLASSES) begin : g_param_check
            $error("dense_4_argmax: illegal parameter combination");
        end
    endgenerate

    logic [1:0]                    state_reg;
    logic [N_CLASSES*WIDTH-1:0]    data_reg;
    logic [IDX_W-1:0]              ptr_reg;
    logic signed [WIDTH-1:0]       best_reg;
    logic signed [WIDTH-1:0]       second_reg;
    logic [IDX_W-1:0]              best_idx_reg;
    logic [IDX_W-1:0]              out_class_reg;
    logic signed [WIDTH-1:0]       out_max_reg;
    logic [WIDTH:0]                out_margin_reg;

    logic signed [WIDTH-1:0]       scores [N_CLASSES];
    logic signed [WIDTH-1:0]       cur_score;
    logic signed [WIDTH-1:0]       best_next;
    logic signed [WIDTH-1:0]       second_next;
    logic [IDX_W-1:0]              best_idx_next;
    logic [WIDTH:0]                margin_next;

    generate
        for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_unpack
            assign scores[gi] = data_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign cur_score = scores[ptr_reg];

    // Strict '>' keeps the lowest index on ties while still letting an equal
    // score become the runner-up.
    always_comb begin
        best_next     = best_reg;
        second_next   = second_reg;
        best_idx_next = best_idx_reg;
        if (cur_score > best_reg) begin
            second_next   = best_reg;
            best_next     = cur_score;
            best_idx_next = ptr_reg;
        end else if (cur_score > second_reg) begin
            second_next = cur_score;
        end
        margin_next = {best_next[WIDTH-1], best_next} - {second_next[WIDTH-1], second_next};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            data_reg       <= '0;
            ptr_reg        <= '0;
            best_reg       <= '0;
            second_reg     <= '0;
            best_idx_reg   <= '0;
            out_class_reg  <= '0;
            out_max_reg    <= '0;
            out_margin_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_data;
                        best_reg     <= in_data[WIDTH-1:0];
                        best_idx_reg <= '0;
                        second_reg   <= MIN_SCORE;
                        ptr_reg      <= IDX_W'(1);
                        state_reg    <= SCAN;
                    end
                end
                SCAN: begin
                    best_reg     <= best_next;
                    second_reg   <= second_next;
                    best_idx_reg <= best_idx_next;
                    ptr_reg      <= ptr_reg + 1'b1;
                    if (ptr_reg == LAST_IDX) begin
                        out_class_reg  <= best_idx_next;
                        out_max_reg    <= best_next;
                        out_margin_reg <= margin_next;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by reset so the block never advertises readiness while held in reset.
    assign in_ready   = (state_reg == IDLE) && !reset;
    assign out_valid  = (state_reg == DONE);
    assign out_class  = out_class_reg;
    assign out_max    = out_max_reg;
    assign out_margin = out_margin_reg;

endmodule
